// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: start bit, DATA_BITS data bits sent LSB first, optional parity bit,
// STOP_BITS stop bits, with a one-entry holding buffer. Parity bit enabled by macro UART_TX_PARITY_EN.
module uart_tx_buffered #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_tx_valid,
  input  logic [DATA_BITS-1:0] i_data_in,
  output logic                 o_tx_ready,
  output logic                 o_tx,
  output logic                 o_tx_busy,
  output logic                 o_frame_done
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam bit            TWO_STOP  = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [TW-1:0]          r_tick_cnt, w_tick_nxt;
  logic [BW-1:0]          r_bit_cnt, w_bit_nxt;
  logic                   r_stop_cnt, w_stop_nxt;
  logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
  logic [DATA_BITS-1:0]   r_buf, w_buf_nxt;
  logic                   r_buf_valid, w_buf_valid_nxt;
  logic                   r_tx, w_tx_nxt;
  logic                   r_frame_done, w_frame_done_nxt;
  logic                   w_accept;
  logic                   w_bit_end;
  logic                   w_load;
  logic [DATA_BITS-1:0]   w_load_data;
`ifdef UART_TX_PARITY_EN
  logic                   r_parity, w_parity_nxt;
`else
  logic                   w_unused_parity_odd;
  assign w_unused_parity_odd = 1'(PARITY_ODD);
`endif

  assign o_tx_ready   = !r_buf_valid && !i_reset;
  assign w_accept     = i_tx_valid && o_tx_ready;
  assign w_bit_end    = (r_state != S_IDLE) && i_tick && (r_tick_cnt == TICK_LAST);
  assign o_tx         = r_tx;
  assign o_tx_busy    = (r_state != S_IDLE);
  assign o_frame_done = r_frame_done;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_tick_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_stop_cnt   <= 1'b0;
      r_buf_valid  <= 1'b0;
      r_tx         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_tick_cnt   <= w_tick_nxt;
      r_bit_cnt    <= w_bit_nxt;
      r_stop_cnt   <= w_stop_nxt;
      r_buf_valid  <= w_buf_valid_nxt;
      r_tx         <= w_tx_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  // Datapath registers carry no reset; they are only consumed under valid control state.
  always_ff @(posedge i_clock) begin
    r_shift <= w_shift_nxt;
    r_buf   <= w_buf_nxt;
`ifdef UART_TX_PARITY_EN
    r_parity <= w_parity_nxt;
`endif
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_tick_nxt       = r_tick_cnt;
    w_bit_nxt        = r_bit_cnt;
    w_stop_nxt       = r_stop_cnt;
    w_shift_nxt      = r_shift;
    w_buf_nxt        = r_buf;
    w_buf_valid_nxt  = r_buf_valid;
    w_tx_nxt         = r_tx;
    w_frame_done_nxt = 1'b0;
    w_load           = 1'b0;
    w_load_data      = i_data_in;
`ifdef UART_TX_PARITY_EN
    w_parity_nxt     = r_parity;
`endif

    if (w_accept && (r_state != S_IDLE)) begin
      w_buf_nxt       = i_data_in;
      w_buf_valid_nxt = 1'b1;
    end

    if ((r_state != S_IDLE) && i_tick) begin
      w_tick_nxt = (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + TW'(1);
    end

    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (w_accept) w_load = 1'b1;
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
            w_tx_nxt    = r_parity;
`else
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
`endif
            w_stop_nxt  = 1'b0;
          end else begin
            w_bit_nxt = r_bit_cnt + BW'(1);
            w_tx_nxt  = r_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
          w_stop_nxt  = 1'b0;
          w_tx_nxt    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          if (TWO_STOP && !r_stop_cnt) begin
            w_stop_nxt = 1'b1;
          end else begin
            w_frame_done_nxt = 1'b1;
            // Chain straight into the next start bit so back-to-back frames have no idle gap.
            if (r_buf_valid) begin
              w_load          = 1'b1;
              w_load_data     = r_buf;
              w_buf_valid_nxt = 1'b0;
            end else if (w_accept) begin
              w_load          = 1'b1;
              w_buf_valid_nxt = 1'b0;
            end else begin
              w_state_nxt = S_IDLE;
              w_tx_nxt    = 1'b1;
            end
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tick_nxt  = '0;
        w_tx_nxt    = 1'b1;
      end
    endcase

    if (w_load) begin
      w_shift_nxt = w_load_data;
      w_state_nxt = S_START;
      w_tick_nxt  = '0;
      w_bit_nxt   = '0;
      w_stop_nxt  = 1'b0;
      w_tx_nxt    = 1'b0;
`ifdef UART_TX_PARITY_EN
      w_parity_nxt = (^w_load_data) ^ 1'(PARITY_ODD);
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: an 8N1 instance and a 7-bit, 2-stop, odd-parity instance
// driven from one linear sequence; parity frames are expected when UART_TX_PARITY_EN is defined.
module tb_uart_tx_buffered;

  localparam int OVS = 16;

`ifdef UART_TX_PARITY_EN
  localparam int L8 = 11;
  localparam int L7 = 11;
  localparam logic [15:0] F_A5   = {5'd0, 1'b1, 1'b0, 8'hA5, 1'b0};
  localparam logic [15:0] F_3C   = {5'd0, 1'b1, 1'b0, 8'h3C, 1'b0};
  localparam logic [15:0] F_C3   = {5'd0, 1'b1, 1'b0, 8'hC3, 1'b0};
  localparam logic [15:0] F_07_8 = {5'd0, 1'b1, 1'b1, 8'h07, 1'b0};
  localparam logic [15:0] F_5A   = {5'd0, 1'b1, 1'b0, 8'h5A, 1'b0};
  localparam logic [15:0] F_55_7 = {5'd0, 2'b11, 1'b1, 7'h55, 1'b0};
  localparam logic [15:0] F_07_7 = {5'd0, 2'b11, 1'b0, 7'h07, 1'b0};
`else
  localparam int L8 = 10;
  localparam int L7 = 10;
  localparam logic [15:0] F_A5   = {6'd0, 1'b1, 8'hA5, 1'b0};
  localparam logic [15:0] F_3C   = {6'd0, 1'b1, 8'h3C, 1'b0};
  localparam logic [15:0] F_C3   = {6'd0, 1'b1, 8'hC3, 1'b0};
  localparam logic [15:0] F_07_8 = {6'd0, 1'b1, 8'h07, 1'b0};
  localparam logic [15:0] F_5A   = {6'd0, 1'b1, 8'h5A, 1'b0};
  localparam logic [15:0] F_55_7 = {6'd0, 2'b11, 7'h55, 1'b0};
  localparam logic [15:0] F_07_7 = {6'd0, 2'b11, 7'h07, 1'b0};
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       tick_en = 1'b1;
  logic       sel = 1'b0;
  logic       valid8 = 1'b0, valid7 = 1'b0;
  logic [7:0] data8 = '0;
  logic [6:0] data7 = '0;
  logic       ready8, tx8, busy8, fd8;
  logic       ready7, tx7, busy7, fd7;
  logic       obs_ready, obs_tx, obs_busy, obs_fd;
  int         total = 0;
  int         bad = 0;

  uart_tx_buffered #(.DATA_BITS(8), .OVERSAMPLE(OVS), .STOP_BITS(1), .PARITY_ODD(0)) u_dut8 (
    .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_tx_valid(valid8), .i_data_in(data8),
    .o_tx_ready(ready8), .o_tx(tx8), .o_tx_busy(busy8), .o_frame_done(fd8)
  );

  uart_tx_buffered #(.DATA_BITS(7), .OVERSAMPLE(OVS), .STOP_BITS(2), .PARITY_ODD(1)) u_dut7 (
    .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_tx_valid(valid7), .i_data_in(data7),
    .o_tx_ready(ready7), .o_tx(tx7), .o_tx_busy(busy7), .o_frame_done(fd7)
  );

  assign obs_ready = sel ? ready7 : ready8;
  assign obs_tx    = sel ? tx7    : tx8;
  assign obs_busy  = sel ? busy7  : busy8;
  assign obs_fd    = sel ? fd7    : fd8;

  initial forever #5 clk = ~clk;

  // Tick is updated just after each rising edge, so at a falling edge it shows what the next edge samples.
  initial begin
    int tcnt;
    tcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_en) begin
        tcnt = (tcnt + 1) % 4;
        tick = (tcnt == 3);
      end else begin
        tick = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [8:0] d, input string tag);
    chk({tag, "_idle_tx"}, 32'(obs_tx), 32'd1);
    chk({tag, "_idle_ready"}, 32'(obs_ready), 32'd1);
    if (sel) begin valid7 = 1'b1; data7 = d[6:0]; end
    else     begin valid8 = 1'b1; data8 = d[7:0]; end
    @(negedge clk);
    valid7 = 1'b0;
    valid8 = 1'b0;
    data7  = ~data7;
    data8  = ~data8;
  endtask

  // Called at the falling edge after the frame's start bit was launched; returns at the
  // falling edge just before the edge that ends the last stop bit.
  task automatic run_frame(input logic [15:0] bits, input int len, input string tag);
    int ticks, bit_i, errs, fd_hi, guard;
    bit first;
    ticks = 0; bit_i = 0; errs = 0; fd_hi = 0; guard = 0; first = 1'b1;
    while (bit_i < len && guard < 5000) begin
      if (obs_tx !== bits[bit_i]) errs++;
      if (obs_busy !== 1'b1) errs++;
      if (!first && obs_fd) fd_hi++;
      first = 1'b0;
      if (tick) begin
        ticks++;
        if (ticks == OVS) begin
          chk($sformatf("%s_bit%0d", tag, bit_i), 32'(errs), 32'd0);
          errs  = 0;
          ticks = 0;
          bit_i++;
          if (bit_i == len) break;
        end
      end
      @(negedge clk);
      guard++;
    end
    chk({tag, "_timeout"}, 32'(guard < 5000), 32'd1);
    chk({tag, "_fd_early"}, 32'(fd_hi), 32'd0);
  endtask

  task automatic end_frame_idle(input string tag);
    @(negedge clk);
    chk({tag, "_fd_pulse"}, 32'(obs_fd), 32'd1);
    chk({tag, "_tx_idle"}, 32'(obs_tx), 32'd1);
    chk({tag, "_busy_drop"}, 32'(obs_busy), 32'd0);
    @(negedge clk);
    chk({tag, "_fd_one_cycle"}, 32'(obs_fd), 32'd0);
  endtask

  initial begin
    int n, errs;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx8), 32'd1);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_fd", 32'(fd8), 32'd0);
    chk("rst_ready_low", 32'(ready8), 32'd0);
    chk("rst_tx7", 32'(tx7), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_ready_high", 32'(ready8), 32'd1);
    repeat (2) @(negedge clk);

    // Single frame, line bits 0,1,0,1,0,0,1,0,1,1
    send(9'h0A5, "a5");
    run_frame(F_A5, L8, "a5");
    end_frame_idle("a5");

    // Back-to-back through the holding buffer
    send(9'h03C, "b2b");
    fork
      run_frame(F_3C, L8, "f3c");
      begin
        chk("b2b_ready_busy", 32'(ready8), 32'd1);
        valid8 = 1'b1;
        data8  = 8'hC3;
        @(negedge clk);
        valid8 = 1'b0;
        data8  = 8'h00;
        chk("b2b_ready_full", 32'(ready8), 32'd0);
      end
    join
    @(negedge clk);
    chk("b2b_fd_pulse", 32'(fd8), 32'd1);
    chk("b2b_no_gap", 32'(tx8), 32'd0);
    chk("b2b_busy", 32'(busy8), 32'd1);
    chk("b2b_ready_free", 32'(ready8), 32'd1);
    run_frame(F_C3, L8, "fc3");
    end_frame_idle("fc3");

    // 7 data bits, 2 stop bits, odd parity instance
    sel = 1'b1;
    @(negedge clk);
    send(9'h055, "s55");
    run_frame(F_55_7, L7, "s55");
    end_frame_idle("s55");
    send(9'h007, "p07_7");
    run_frame(F_07_7, L7, "p07_7");
    end_frame_idle("p07_7");
    sel = 1'b0;
    @(negedge clk);
    send(9'h007, "p07_8");
    run_frame(F_07_8, L8, "p07_8");
    end_frame_idle("p07_8");

    // Tick stalled for 100 clocks mid-bit
    send(9'h05A, "pause");
    fork
      run_frame(F_5A, L8, "pause");
      begin
        repeat (150) @(negedge clk);
        tick_en = 1'b0;
        repeat (100) @(negedge clk);
        tick_en = 1'b1;
      end
    join
    end_frame_idle("pause");

    // Reset during data bit 3 with a byte pending
    send(9'h096, "rstm");
    chk("rstm_ready_pre", 32'(ready8), 32'd1);
    valid8 = 1'b1;
    data8  = 8'h81;
    @(negedge clk);
    valid8 = 1'b0;
    chk("rstm_ready_full", 32'(ready8), 32'd0);
    n = 0;
    while (n < 70) begin
      if (tick) n++;
      @(negedge clk);
    end
    chk("rstm_bit3_tx", 32'(tx8), 32'd0);
    chk("rstm_bit3_busy", 32'(busy8), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstm_ready_in_rst", 32'(ready8), 32'd0);
    @(negedge clk);
    chk("rstm_tx", 32'(tx8), 32'd1);
    chk("rstm_busy", 32'(busy8), 32'd0);
    chk("rstm_fd", 32'(fd8), 32'd0);
    chk("rstm_ready_still", 32'(ready8), 32'd0);
    rst = 1'b0;
    #1;
    chk("rstm_ready_after", 32'(ready8), 32'd1);
    errs = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx8 !== 1'b1 || busy8 !== 1'b0 || fd8 !== 1'b0) errs++;
    end
    chk("rstm_pending_dropped", 32'(errs), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Parametrised UART transmitter; next generation of the team's fixed 8N1 transmitter.
- Configurable data width, oversample ratio and stop-bit count.
- Valid/ready byte-input handshake with a one-entry holding buffer, so back-to-back frames go out with no idle gap.
- Sits between a host-side byte source (FIFO or CPU register) and the TX pin; fed by the shared baud-rate tick generator.

Parameters:
- DATA_BITS, 8, data bits per frame, legal 5..9, sent LSB first.
- OVERSAMPLE, 16, Tick pulses per bit period, legal 2..64.
- STOP_BITS, 1, number of stop bits, legal 1 or 2.
- PARITY_ODD, 0, parity sense (0 even, 1 odd); used only when UART_TX_PARITY_EN is defined.

Ports:
- Clock  input  1  system clock; all logic on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Tick  input  1  one-Clock-wide baud tick, OVERSAMPLE pulses per bit.
- TxValid  input  1  DataIn holds a byte to send.
- DataIn  input  DATA_BITS  byte to transmit.
- TxReady  output  1  holding buffer can accept a byte.
- Tx  output  1  serial line, idle high.
- TxBusy  output  1  frame in progress (state != IDLE).
- FrameDone  output  1  one-cycle pulse when the last stop bit completes.

Behaviour:
- Reset (Reset=1 at a rising edge):
  - State=IDLE, Tx=1, TickCount=0, BitCount=0, buffer empty, FrameDone=0.
  - TxReady=0 while Reset is high; TxReady=1 in the first cycle after Reset falls.
  - Reset mid-frame aborts the frame: Tx=1 after that edge and the pending byte is discarded.
- Accept rule:
  - A byte is accepted at an edge where TxValid && TxReady.
  - TxReady = !BufValid, derived only from registers (no combinational path from TxValid).
- IDLE:
  - An accepted byte loads the shift register directly, not the buffer.
  - At that same edge: State=START, TickCount=0, Tx register=0. Tx therefore falls in the cycle after acceptance (latency 1 clock).
- While State != IDLE:
  - An accepted byte goes to the holding buffer; BufValid=1 and TxReady=0 until it is consumed.
- Bit timing, applied in every non-IDLE state:
  - TickCount advances only on Tick=1.
  - At Tick with TickCount==OVERSAMPLE-1 the bit ends, TickCount resets to 0, and the next state and Tx register update at that edge.
  - Clocks without Tick hold all counters.
- States and transitions:
  - START: Tx=0 for one bit, then DATA with BitCount=0.
  - DATA: Tx=shift[0]; the shift register shifts right at each bit end; after bit DATA_BITS-1, go to PARITY if the macro is enabled, else STOP.
  - STOP: Tx=1 for STOP_BITS bit periods (a sub-count tracks the second stop bit when STOP_BITS=2).
- End of the last stop bit:
  - FrameDone=1 for exactly one cycle.
  - If BufValid=1: load the buffer into the shift register, clear BufValid, go to START with Tx=0 at the same edge (no idle bit).
  - Else if TxValid=1 at that edge (TxReady is 1): load DataIn directly and go to START.
  - Else: go to IDLE with Tx=1.
- Widths and counters:
  - TickCount is $clog2(OVERSAMPLE) bits; BitCount is $clog2(DATA_BITS) bits.
  - Counters never wrap mid-bit; the terminal compare is exact equality.
- Hold rules:
  - DataIn changes after acceptance have no effect on the current frame.
  - The buffer contents are held stable until consumed.
- Tick during IDLE is ignored.
- Any illegal state encoding goes to IDLE with Tx=1.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, one bit period long.
  - Tx = XOR of the frame's DATA_BITS data bits, XOR PARITY_ODD.
  - The parity value is computed at load time and held in a register.
- Undefined:
  - No PARITY state, no parity register; DATA goes straight to STOP.
  - PARITY_ODD is ignored.

Test Plan:
- Defaults, Tick every 4 clocks, accept 8'hA5 in IDLE -> Tx falls 1 clock later; line carries 0,1,0,1,0,0,1,0,1,1, each bit 64 clocks; FrameDone pulses once; TxBusy drops after the stop bit.
- Accept 8'h3C, then 8'hC3 while busy -> TxReady=0 after the second accept; after the first stop bit, START of 8'hC3 begins at the same edge FrameDone pulses; no idle-high gap.
- DATA_BITS=7, STOP_BITS=2, 7'h55 -> 1 start + 7 data + 2 stop bits; frame is 10*OVERSAMPLE ticks.
- UART_TX_PARITY_EN, PARITY_ODD=0, 8'h07 -> parity bit 1; same with PARITY_ODD=1 -> parity bit 0.
- Reset pulsed during data bit 3 with a byte pending -> Tx=1 after that edge; TxReady=0 while Reset high, 1 the cycle after; the pending byte is never transmitted.
- Tick held low for 100 clocks mid-bit -> Tx and all counters hold; the bit resumes and completes with exactly OVERSAMPLE ticks counted in total.
